// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cacheline adaptor between the icache and the dcache.
//
// One transaction is in flight at a time. In IDLE a pending request is granted
// and its line-aligned address, write data and operation are latched; the
// SERVE state then drives the adaptor from those latches until ca_resp, which
// is forwarded combinationally to the winner only. A single RECOVER cycle
// follows every completion so a requester can drop its request before it
// could be granted again.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_pmem_read/address              icache line-fill request
//   i_pmem_rdata/resp                line and completion pulse to icache
//   d_pmem_read/write/address/wdata  dcache fill / writeback request
//   d_pmem_rdata/resp                line and completion pulse to dcache
//   ca_read/write/address/wdata      downstream request (address line-aligned)
//   ca_rdata/resp                    downstream read line and completion

module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned OFFSET_BITS = 5,
  parameter bit          RR_ENABLE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  ca_read,
  output logic                  ca_write,
  output logic [ADDR_WIDTH-1:0] ca_address,
  output logic [LINE_WIDTH-1:0] ca_wdata,
  input  logic [LINE_WIDTH-1:0] ca_rdata,
  input  logic                  ca_resp
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StServeI  = 2'd1;
  localparam logic [1:0] StServeD  = 2'd2;
  localparam logic [1:0] StRecover = 2'd3;

  // Clears the line-offset bits of a requester address.
  localparam logic [ADDR_WIDTH-1:0] LineMask =
      ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  logic [1:0]            state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1: most recent grant went to dcache
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;

  logic i_req, d_req, pick_d, serving;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // dcache wins unless icache also requests and round-robin says it is I's turn.
  assign pick_d = d_req & (~i_req | ~RR_ENABLE | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    unique case (state_q)
      StIdle: begin
        if (i_req | d_req) begin
          state_d  = pick_d ? StServeD : StServeI;
          last_d_d = pick_d;
          addr_d   = (pick_d ? d_pmem_address : i_pmem_address) & LineMask;
          wdata_d  = pick_d ? d_pmem_wdata : '0;
          // Write takes precedence if the dcache raises both read and write.
          wr_d     = pick_d & d_pmem_write;
        end
      end
      StServeI, StServeD: begin
        if (ca_resp) state_d = StRecover;
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  assign serving = (state_q == StServeI) | (state_q == StServeD);

  // Requests drop in the completion cycle itself.
  assign ca_read    = serving & ~wr_q & ~ca_resp;
  assign ca_write   = serving &  wr_q & ~ca_resp;
  assign ca_address = addr_q;
  assign ca_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == StServeI) & ca_resp;
  assign d_pmem_resp  = (state_q == StServeD) & ca_resp;
  assign i_pmem_rdata = i_pmem_resp ? ca_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? ca_rdata : '0;

endmodule
